// File: rtl/vga_scaler.sv
// VGA scan-out with integer upscaling, fixed framebuffer read latency absorption and RGB bit-replication.
// Optional border colour outside the scaled image: define VGA_SCALER_BORDER_EN.
module vga_scaler #(
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int          SCALE      = 2,
  parameter int          SRC_W      = 320,
  parameter int          SRC_H      = 240,
  parameter int          R_BITS     = 3,
  parameter int          G_BITS     = 3,
  parameter int          B_BITS     = 2,
  parameter int          RD_LAT     = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  localparam int         PW         = R_BITS + G_BITS + B_BITS,
  localparam int         XW         = (SRC_W > 1) ? $clog2(SRC_W) : 1,
  localparam int         YW         = (SRC_H > 1) ? $clog2(SRC_H) : 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          pix_ce_in,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          rd_en_out,
  input  logic [PW-1:0] rgb_in,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic          between_frames,
  output logic          frame_start_out
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_END    = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] IMG_W    = HW'(SRC_W * SCALE);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_END    = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] IMG_H    = VW'(SRC_H * SCALE);
  localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);

`ifdef VGA_SCALER_BORDER_EN
  localparam logic [23:0] BORDER_C = BORDER_RGB;
`else
  // Border pixels are black; the parameter has no effect in this build.
  localparam logic [23:0] BORDER_C = BORDER_RGB & 24'h000000;
`endif

  // Delay-line bundle: {frame_start, in_image, de, v_active, vsync, hsync}
  localparam logic [5:0] IDLE = {4'b0000, ~VS_POL, ~HS_POL};

  function automatic logic [7:0] expand(input logic [7:0] f, input int n);
    logic [7:0] res;
    logic [2:0] idx;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(n - 1 - (i % n));
      res[3'(7 - i)] = f[idx];
    end
    return res;
  endfunction

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [SW-1:0] r_sx;
  logic [SW-1:0] r_sy;
  logic [5:0]    r_dly [RD_LAT];

  logic [HW-1:0] w_dx;
  logic [VW-1:0] w_dy;
  logic [VW-1:0] w_v_next;
  logic [VW-1:0] w_dy_next;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_in_img;
  logic          w_v_img;
  logic          w_vn_img;
  logic [5:0]    w_stage;
  logic [5:0]    w_tail;
  logic [23:0]   w_colour;

  always_comb begin
    w_dx      = r_hcnt - H_START;
    w_dy      = r_vcnt - V_START;
    w_h_act   = (r_hcnt >= H_START) && (r_hcnt < H_END);
    w_v_act   = (r_vcnt >= V_START) && (r_vcnt < V_END);
    w_v_img   = w_v_act && (w_dy < IMG_H);
    w_in_img  = w_h_act && (w_dx < IMG_W) && w_v_img;
    w_v_next  = (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    w_dy_next = w_v_next - V_START;
    w_vn_img  = (w_v_next >= V_START) && (w_dy_next < IMG_H);
    w_stage   = {(r_hcnt == '0) && (r_vcnt == '0), w_in_img, w_h_act && w_v_act, w_v_act,
                 (r_vcnt < V_SYNC_E) ? VS_POL : ~VS_POL,
                 (r_hcnt < H_SYNC_E) ? HS_POL : ~HS_POL};
    w_tail    = r_dly[RD_LAT-1];
    w_colour  = '0;
    if (w_tail[3]) begin
      if (w_tail[4]) begin
        w_colour = {expand(8'(rgb_in[PW-1 -: R_BITS]), R_BITS),
                    expand(8'(rgb_in[B_BITS+G_BITS-1 -: G_BITS]), G_BITS),
                    expand(8'(rgb_in[B_BITS-1:0]), B_BITS)};
      end else begin
        w_colour = BORDER_C;
      end
    end
  end

  // Timing counters and source address; x/y hold whenever the pixel lies outside the image
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_sx      <= '0;
      r_sy      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      rd_en_out <= 1'b0;
    end else if (pix_ce_in) begin
      if (r_hcnt == H_LAST) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_next;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      rd_en_out <= w_in_img;
      if (w_in_img) begin
        if (r_hcnt == H_START) begin
          x_out <= '0;
          r_sx  <= '0;
        end else if (r_sx == S_LAST) begin
          x_out <= x_out + 1'b1;
          r_sx  <= '0;
        end else begin
          r_sx <= r_sx + 1'b1;
        end
      end
      if (r_hcnt == H_LAST) begin
        if (w_v_next == V_START) begin
          y_out <= '0;
          r_sy  <= '0;
        end else if (w_v_img && w_vn_img) begin
          if (r_sy == S_LAST) begin
            y_out <= y_out + 1'b1;
            r_sy  <= '0;
          end else begin
            r_sy <= r_sy + 1'b1;
          end
        end
      end
    end
  end

  // Delay line matching the framebuffer latency, then the output register stage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RD_LAT; i++) r_dly[i] <= IDLE;
      hsync_out       <= ~HS_POL;
      vsync_out       <= ~VS_POL;
      de_out          <= 1'b0;
      between_frames  <= 1'b1;
      frame_start_out <= 1'b0;
      r_out           <= '0;
      g_out           <= '0;
      b_out           <= '0;
    end else if (pix_ce_in) begin
      r_dly[0] <= w_stage;
      for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
      hsync_out       <= w_tail[0];
      vsync_out       <= w_tail[1];
      between_frames  <= ~w_tail[2];
      de_out          <= w_tail[3];
      frame_start_out <= w_tail[5];
      r_out           <= w_colour[23:16];
      g_out           <= w_colour[15:8];
      b_out           <= w_colour[7:0];
    end
  end

endmodule

// File: tb/tb_vga_scaler.sv
// Bench for vga_scaler on a shrunken timing: random pixel data, per-cycle reference model, frame counts, ce gating, async reset.
module tb_vga_scaler;
  localparam int H_SYNC = 4, H_BP = 3, H_ACTIVE = 20, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 2, V_ACTIVE = 12, V_FP = 2;
  localparam logic HS_POL = 1'b0, VS_POL = 1'b0;
  localparam int SCALE = 2, SRC_W = 8, SRC_H = 5, RD_LAT = 3;
  localparam int R_BITS = 3, G_BITS = 3, B_BITS = 2;
  localparam logic [23:0] BORDER_RGB = 24'h0000FF;
  localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int F  = HT * VT;
  localparam int HS0 = H_SYNC + H_BP;
  localparam int VS0 = V_SYNC + V_BP;
`ifdef VGA_SCALER_BORDER_EN
  localparam logic [23:0] BORDER_EXP = BORDER_RGB;
`else
  localparam logic [23:0] BORDER_EXP = 24'h000000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_ce = 1'b0;
  logic [7:0] rgb_in = 8'h00;
  logic [2:0] x_out;
  logic [2:0] y_out;
  logic       rd_en_out;
  logic [7:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out, de_out, between_frames, frame_start_out;

  vga_scaler #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .SCALE(SCALE), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .R_BITS(R_BITS), .G_BITS(G_BITS), .B_BITS(B_BITS), .RD_LAT(RD_LAT), .BORDER_RGB(BORDER_RGB)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pix_ce_in(pix_ce),
    .x_out(x_out), .y_out(y_out), .rd_en_out(rd_en_out), .rgb_in(rgb_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .between_frames(between_frames), .frame_start_out(frame_start_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_edges = 0;
  logic [7:0] dat[$];
  int mx = 0, my = 0;
  logic exp_rd = 1'b0;
  logic [31:0] prev_obs = '0;
  int win_lo = 0;
  int c_hs = 0, c_vs = 0, c_de = 0, c_fs = 0;
  int first_de_n = -1, first_fs_n = -1;
  logic prev_de = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expand8(input int f, input int nb);
    int acc, len;
    acc = 0;
    len = 0;
    while (len < 8) begin
      acc = (acc << nb) | f;
      len += nb;
    end
    return 8'(acc >> (len - 8));
  endfunction

  function automatic logic in_img(input int h, input int v);
    return (h >= HS0) && (h - HS0 < SRC_W * SCALE) && (v >= VS0) && (v - VS0 < SRC_H * SCALE);
  endfunction

  function automatic logic [31:0] video_exp();
    int q, pos, h, v, d;
    logic hs, vs, de, fs, bf;
    logic [23:0] c;
    q = n_edges - 1 - RD_LAT;
    if (q < 0) return {3'b000, ~HS_POL, ~VS_POL, 3'b001, 24'h000000};
    pos = q % F;
    h = pos % HT;
    v = pos / HT;
    hs = (h < H_SYNC) ? HS_POL : ~HS_POL;
    vs = (v < V_SYNC) ? VS_POL : ~VS_POL;
    bf = !(v >= VS0 && v < VS0 + V_ACTIVE);
    de = (h >= HS0 && h < HS0 + H_ACTIVE) && !bf;
    fs = (pos == 0);
    d = int'(dat[n_edges - 1]);
    c = 24'h0;
    if (de) begin
      if (in_img(h, v))
        c = {expand8((d >> (G_BITS + B_BITS)) & ((1 << R_BITS) - 1), R_BITS),
             expand8((d >> B_BITS) & ((1 << G_BITS) - 1), G_BITS),
             expand8(d & ((1 << B_BITS) - 1), B_BITS)};
      else
        c = BORDER_EXP;
    end
    return {3'b000, hs, vs, de, fs, bf, c};
  endfunction

  task automatic model_reset();
    n_edges = 0;
    dat.delete();
    mx = 0;
    my = 0;
    exp_rd = 1'b0;
  endtask

  task automatic tick(input logic ce_v);
    logic [7:0] d;
    int p, h, v, q;
    logic [31:0] obs;
    d = 8'($urandom);
    pix_ce = ce_v;
    rgb_in = d;
    @(posedge clk);
    if (ce_v && rst_n) begin
      dat.push_back(d);
      n_edges++;
      p = (n_edges - 1) % F;
      h = p % HT;
      v = p / HT;
      exp_rd = in_img(h, v);
      if (exp_rd) begin
        mx = (h - HS0) / SCALE;
        my = (v - VS0) / SCALE;
      end
    end
    @(negedge clk);
    obs = {3'b000, hsync_out, vsync_out, de_out, frame_start_out, between_frames, r_out, g_out, b_out};
    chk("addr", {28'h0, rd_en_out, x_out}, {28'h0, exp_rd, 3'(mx)});
    if (exp_rd) chk("row", {29'h0, y_out}, 32'(my));
    chk("video", obs, video_exp());
    if (!ce_v) chk("hold", obs, prev_obs);
    prev_obs = obs;
    if (ce_v && rst_n) begin
      q = n_edges - 1 - RD_LAT;
      if (q >= win_lo && q < win_lo + 2 * F) begin
        if (hsync_out == HS_POL) c_hs++;
        if (vsync_out == VS_POL) c_vs++;
        if (de_out) c_de++;
        if (frame_start_out) c_fs++;
      end
      if (de_out && !prev_de && first_de_n < 0) first_de_n = n_edges;
      if (frame_start_out && first_fs_n < 0) first_fs_n = n_edges;
      prev_de = de_out;
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hsync"}, 32'(c_hs), 32'(2 * VT * H_SYNC));
    chk({tag, "_vsync"}, 32'(c_vs), 32'(2 * V_SYNC * HT));
    chk({tag, "_de"},    32'(c_de), 32'(2 * H_ACTIVE * V_ACTIVE));
    chk({tag, "_fs"},    32'(c_fs), 32'd2);
    c_hs = 0; c_vs = 0; c_de = 0; c_fs = 0;
  endtask

  initial begin
    int guard;
    // Reset held: outputs idle, ce activity ignored
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("rst_y", {29'h0, y_out}, 32'h0);

    // Continuous run, two frames plus pipeline fill
    rst_n = 1'b1;
    model_reset();
    win_lo = 0;
    for (int i = 0; i < 2 * F + RD_LAT; i++) tick(1'b1);
    chk_counts("cont");
    chk("de_rise", 32'(first_de_n), 32'(VS0 * HT + HS0 + RD_LAT + 1));
    chk("fs_first", 32'(first_fs_n), 32'(RD_LAT + 1));

    // ce toggling 1,0 over the next two frames
    win_lo = 2 * F;
    while (n_edges < 4 * F + RD_LAT) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk_counts("gated");

    // Asynchronous reset in the middle of an image line
    guard = 0;
    while (((n_edges - 1) % F) != 6 * HT + 15 && guard < 2 * F) begin
      tick(1'b1);
      guard++;
    end
    chk("reach_pos", 32'((n_edges - 1) % F), 32'(6 * HT + 15));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_video", {3'b000, hsync_out, vsync_out, de_out, frame_start_out, between_frames, r_out, g_out, b_out},
        video_exp());
    chk("async_addr", {25'h0, rd_en_out, x_out, y_out}, 32'h0);
    @(negedge clk);
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;
    first_fs_n = -1;
    first_de_n = -1;
    prev_de = 1'b0;
    win_lo = 1 << 30;
    for (int i = 0; i < F + 40; i++) tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    chk("fs_after_rst", 32'(first_fs_n), 32'(RD_LAT + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
